// File: rtl/axi_slv_pkg.sv
// Shared types and constants for the AXI SRAM slave.
package axi_slv_pkg;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  // Limit a requested beats-1 value to the largest supported burst.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input int unsigned      max_len);
    return (len > LEN_W'(max_len)) ? LEN_W'(max_len) : len;
  endfunction

  // Maximal-length 16-bit Fibonacci LFSR step (x^16+x^14+x^13+x^11+1).
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3 read/write channel bundle between a master and the SRAM slave.
interface axi_sram_slave_if;
  import axi_slv_pkg::*;

  logic [ID_W-1:0]   arid;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic [ID_W-1:0]   awid;
  logic [31:0]       awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [1:0]        awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;

  logic [ID_W-1:0]   wid;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

endinterface

// File: rtl/axi_slv_mem.sv
// Word-addressed SRAM array: byte-strobed synchronous write, asynchronous read.
// Contents are never reset.
module axi_slv_mem
  import axi_slv_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rd_data_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Byte-lane write; a same-edge read of this word still sees the old value.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rd_data_c = mem_q[raddr_i];

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave responder over an on-chip SRAM. Independent read and write
// channels, one outstanding transaction each, INCR-only word bursts.
// Define AXI_SLV_RAND_DELAY_EN to add LFSR-driven random handshake stalls.
module axi_sram_slave
  import axi_slv_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned MAX_LEN = 15
) (
  input  logic         aclk,
  input  logic         aresetn,
  axi_sram_slave_if.slave s
);

  r_state_e          r_state_q, r_state_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [LEN_W-1:0]  r_beats_q, r_beats_d;
  logic [CNT_W-1:0]  r_cnt_q, r_cnt_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  w_state_e          w_state_q, w_state_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [LEN_W-1:0]  w_beats_q, w_beats_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [ID_W-1:0]   bid_q, bid_d;

  logic [ADDR_W-1:0] mem_raddr_c;
  logic [DATA_W-1:0] mem_rdata_c;
  logic              mem_we_c;

  logic stall_ar, stall_aw, stall_w, stall_rv, stall_b;

`ifdef AXI_SLV_RAND_DELAY_EN
  logic [15:0] lfsr_q;

  // Free-running stall source; each 2-bit field is zero ~25% of cycles.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_next(lfsr_q);
  end

  assign stall_ar = (lfsr_q[1:0] == 2'b00);
  assign stall_aw = (lfsr_q[3:2] == 2'b00);
  assign stall_w  = (lfsr_q[5:4] == 2'b00);
  assign stall_rv = (lfsr_q[7:6] == 2'b00);
  assign stall_b  = (lfsr_q[9:8] == 2'b00);
`else
  assign stall_ar = 1'b0;
  assign stall_aw = 1'b0;
  assign stall_w  = 1'b0;
  assign stall_rv = 1'b0;
  assign stall_b  = 1'b0;
`endif

  axi_slv_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk       (aclk),
    .we_i      (mem_we_c),
    .waddr_i   (w_addr_q),
    .wdata_i   (s.wdata),
    .wstrb_i   (s.wstrb),
    .raddr_i   (mem_raddr_c),
    .rd_data_c (mem_rdata_c)
  );

  // Read port address: AR start word in idle, next word while streaming.
  always_comb begin
    case (r_state_q)
      R_IDLE:  mem_raddr_c = s.araddr[ADDR_W+1:2];
      R_DATA:  mem_raddr_c = r_addr_q + ADDR_W'(1);
      default: mem_raddr_c = r_addr_q;
    endcase
  end

  // Read channel next-state and registered outputs.
  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_beats_d = r_beats_q;
    r_cnt_d   = r_cnt_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: begin
        if (s.arvalid && arready_q) begin
          r_addr_d  = s.araddr[ADDR_W+1:2];
          r_beats_d = clamp_len(s.arlen, MAX_LEN);
          rid_d     = s.arid;
          r_cnt_d   = CNT_W'(RD_LAT - 1);
          if (RD_LAT == 1 && !stall_rv) begin
            rdata_d   = mem_rdata_c;
            rvalid_d  = 1'b1;
            rlast_d   = (r_beats_d == '0);
            r_state_d = R_DATA;
          end else begin
            r_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt_q > CNT_W'(1)) r_cnt_d = r_cnt_q - CNT_W'(1);
        if (r_cnt_q <= CNT_W'(1) && !stall_rv) begin
          rdata_d   = mem_rdata_c;
          rvalid_d  = 1'b1;
          rlast_d   = (r_beats_q == '0);
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && s.rready) begin
          if (r_beats_q == '0) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            r_addr_d  = r_addr_q + ADDR_W'(1);
            r_beats_d = r_beats_q - LEN_W'(1);
            rdata_d   = mem_rdata_c;
            rlast_d   = (r_beats_q == LEN_W'(1));
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE) && !stall_ar;
  end

  // Write channel next-state, memory write enable and registered outputs.
  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_beats_d = w_beats_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    mem_we_c  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s.awvalid && awready_q) begin
          w_addr_d  = s.awaddr[ADDR_W+1:2];
          w_beats_d = clamp_len(s.awlen, MAX_LEN);
          bid_d     = s.awid;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s.wvalid && wready_q) begin
          mem_we_c = 1'b1;
          w_addr_d = w_addr_q + ADDR_W'(1);
          if (w_beats_q == '0) begin
            bvalid_d  = !stall_b;
            w_state_d = W_RESP;
          end else begin
            w_beats_d = w_beats_q - LEN_W'(1);
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && s.bready) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end else if (!bvalid_q && !stall_b) begin
          bvalid_d = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !stall_aw;
    wready_d  = (w_state_d == W_DATA) && !stall_w;
  end

  // Read channel registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_beats_q <= '0;
      r_cnt_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_beats_q <= r_beats_d;
      r_cnt_q   <= r_cnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
    end
  end

  // Write channel registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_beats_q <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_beats_q <= w_beats_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
    end
  end

  assign s.arready = arready_q;
  assign s.rvalid  = rvalid_q;
  assign s.rlast   = rlast_q;
  assign s.rid     = rid_q;
  assign s.rdata   = rdata_q;
  assign s.rresp   = RESP_OKAY;
  assign s.awready = awready_q;
  assign s.wready  = wready_q;
  assign s.bvalid  = bvalid_q;
  assign s.bid     = bid_q;
  assign s.bresp   = RESP_OKAY;

  // Fields the slave deliberately ignores (size, burst, attributes, byte offset).
  logic unused_c;
  assign unused_c = ^{s.araddr[31:ADDR_W+2], s.araddr[1:0], s.arsize, s.arburst,
                      s.arlock, s.arcache, s.arprot,
                      s.awaddr[31:ADDR_W+2], s.awaddr[1:0], s.awsize, s.awburst,
                      s.awlock, s.awcache, s.awprot, s.wid, s.wlast};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized bench for axi_sram_slave against a word-array memory model.
module tb_axi_sram_slave;
  import axi_slv_pkg::*;

  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned RD_LAT  = 1;
  localparam int unsigned MAX_LEN = 15;
  localparam int unsigned DEPTH   = 1 << ADDR_W;

  logic aclk    = 1'b0;
  logic aresetn = 1'b1;

  axi_sram_slave_if bus ();

  axi_sram_slave #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MAX_LEN(MAX_LEN)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s       (bus)
  );

  always #5 aclk = ~aclk;

  logic [31:0] model [DEPTH];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] wd_q [$];
  logic [3:0]  ws_q [$];
  bit          rdy_pat [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic int beats_of(input logic [7:0] len);
    return ((int'(len) > int'(MAX_LEN)) ? int'(MAX_LEN) : int'(len)) + 1;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    int beats, cyc, widx;
    logic [31:0] d;
    logic [3:0]  st;
    beats = beats_of(len);
    widx  = int'(addr[ADDR_W+1:2]);
    @(posedge aclk); #1;
    bus.awvalid = 1'b1; bus.awaddr = addr; bus.awlen = len; bus.awid = id;
    bus.awsize = 3'($urandom); bus.awburst = 2'($urandom);
    cyc = 0;
    @(negedge aclk);
    while (!bus.awready && cyc < 100) begin @(negedge aclk); cyc++; end
    if (!bus.awready) begin check("aw_timeout", 32'd0, 32'd1); bus.awvalid = 1'b0; return; end
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    check("w_rdy_lat", 32'(bus.wready), 32'd1);
    for (int i = 0; i < beats; i++) begin
      d  = (wd_q.size() != 0) ? wd_q.pop_front() : $urandom;
      st = (ws_q.size() != 0) ? ws_q.pop_front() : 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin bus.wvalid = 1'b0; @(posedge aclk); #1; end
      bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = st; bus.wid = id;
      bus.wlast = (i == beats - 1);
      cyc = 0;
      @(negedge aclk);
      while (!bus.wready && cyc < 100) begin @(negedge aclk); cyc++; end
      if (!bus.wready) begin check("w_timeout", 32'd0, 32'd1); bus.wvalid = 1'b0; return; end
      @(posedge aclk);
      model[(widx + i) % DEPTH] = apply_strb(model[(widx + i) % DEPTH], d, st);
      #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("bvalid_after_last", 32'(bus.bvalid), 32'd1);
    repeat ($urandom_range(0, 2)) begin
      @(negedge aclk);
      check("b_hold", 32'(bus.bvalid), 32'd1);
    end
    bus.bready = 1'b1;
    cyc = 0;
    @(negedge aclk);
    while (!bus.bvalid && cyc < 100) begin @(negedge aclk); cyc++; end
    check("bid", 32'(bus.bid), 32'(id));
    check("bresp", 32'(bus.bresp), 32'd0);
    @(posedge aclk); #1;
    bus.bready = 1'b0;
    check("b_drop", 32'(bus.bvalid), 32'd0);
    check("aw_rdy_after_b", 32'(bus.awready), 32'd1);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    int beats, cyc, widx, got;
    beats = beats_of(len);
    widx  = int'(addr[ADDR_W+1:2]);
    got   = 0;
    @(posedge aclk); #1;
    bus.arvalid = 1'b1; bus.araddr = addr; bus.arlen = len; bus.arid = id;
    bus.arsize = 3'($urandom); bus.arburst = 2'($urandom);
    cyc = 0;
    @(negedge aclk);
    while (!bus.arready && cyc < 100) begin @(negedge aclk); cyc++; end
    if (!bus.arready) begin check("ar_timeout", 32'd0, 32'd1); bus.arvalid = 1'b0; return; end
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    check("rd_lat", 32'(bus.rvalid), 32'd1);
    cyc = 0;
    while (got < beats && cyc < 500) begin
      bus.rready = (rdy_pat.size() != 0) ? rdy_pat.pop_front() : ($urandom_range(0, 3) != 0);
      @(negedge aclk);
      cyc++;
      if (bus.rvalid) begin
        check("rdata", bus.rdata, model[(widx + got) % DEPTH]);
        check("rid", 32'(bus.rid), 32'(id));
        check("rlast", 32'(bus.rlast), 32'(got == beats - 1));
        check("rresp", 32'(bus.rresp), 32'd0);
        check("ar_busy", 32'(bus.arready), 32'd0);
        if (bus.rready) got++;
      end
      @(posedge aclk); #1;
    end
    bus.rready = 1'b0;
    if (got < beats) check("r_timeout", 32'(got), 32'(beats));
    check("r_done", 32'(bus.rvalid), 32'd0);
    check("ar_rdy_after_r", 32'(bus.arready), 32'd1);
  endtask

  initial begin
    logic [31:0] old0, old1, d;
    bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 3'd2;
    bus.arburst = 2'd1; bus.arlock = 0; bus.arcache = 0; bus.arprot = 0; bus.rready = 0;
    bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 3'd2;
    bus.awburst = 2'd1; bus.awlock = 0; bus.awcache = 0; bus.awprot = 0;
    bus.wvalid = 0; bus.wid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;

    #2 aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_arready", 32'(bus.arready), 0); check("rst_awready", 32'(bus.awready), 0);
    check("rst_wready", 32'(bus.wready), 0);   check("rst_rvalid", 32'(bus.rvalid), 0);
    check("rst_bvalid", 32'(bus.bvalid), 0);   check("rst_rlast", 32'(bus.rlast), 0);
    check("rst_rid", 32'(bus.rid), 0);         check("rst_bid", 32'(bus.bid), 0);
    check("rst_rdata", bus.rdata, 0);          check("rst_rresp", 32'(bus.rresp), 0);
    check("rst_bresp", 32'(bus.bresp), 0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("arready_post_rst", 32'(bus.arready), 1);
    check("awready_post_rst", 32'(bus.awready), 1);

    // Fill the whole array so every later read has a defined expectation.
    for (int i = 0; i < 16; i++) begin wd_q.push_back($urandom); ws_q.push_back(4'hF); end
    axi_write(32'h0, 8'd15, 4'd1);

    // Single read.
    wd_q.push_back(32'h1234_5678); ws_q.push_back(4'hF);
    axi_write(32'h10, 8'd0, 4'd2);
    axi_read(32'h10, 8'd0, 4'd3);

    // Strobed write over known data.
    wd_q.push_back(32'h1111_1111); ws_q.push_back(4'hF);
    axi_write(32'h20, 8'd0, 4'd1);
    wd_q.push_back(32'hAABB_CCDD); ws_q.push_back(4'b0101);
    axi_write(32'h20, 8'd0, 4'd5);
    axi_read(32'h20, 8'd0, 4'd6);

    // 4-beat read with a fixed rready pattern.
    for (int i = 0; i < 4; i++) begin wd_q.push_back(32'(i)); ws_q.push_back(4'hF); end
    axi_write(32'h0, 8'd3, 4'd2);
    rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    axi_read(32'h0, 8'd3, 4'd4);

    // AR and W handshakes on the same edge, both on word 8.
    @(posedge aclk); #1;
    bus.awvalid = 1'b1; bus.awaddr = 32'h20; bus.awlen = 8'd0; bus.awid = 4'd13;
    @(negedge aclk);
    check("coll_awready", 32'(bus.awready), 1);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    old0 = model[8]; old1 = model[9];
    bus.arvalid = 1'b1; bus.araddr = 32'h20; bus.arlen = 8'd1; bus.arid = 4'd14;
    bus.wvalid = 1'b1; bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF; bus.wlast = 1'b1;
    @(negedge aclk);
    check("coll_arready", 32'(bus.arready), 1);
    check("coll_wready", 32'(bus.wready), 1);
    @(posedge aclk);
    model[8] = 32'hDEAD_BEEF;
    #1;
    bus.arvalid = 1'b0; bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("coll_rvalid", 32'(bus.rvalid), 1);
    check("coll_old", bus.rdata, old0);
    bus.rready = 1'b1;
    @(posedge aclk); #1;
    check("coll_beat1", bus.rdata, old1);
    check("coll_rlast", 32'(bus.rlast), 1);
    @(posedge aclk); #1;
    bus.rready = 1'b0;
    check("coll_rdone", 32'(bus.rvalid), 0);
    bus.bready = 1'b1;
    @(negedge aclk);
    check("coll_bvalid", 32'(bus.bvalid), 1);
    check("coll_bid", 32'(bus.bid), 13);
    @(posedge aclk); #1;
    bus.bready = 1'b0;
    axi_read(32'h20, 8'd0, 4'd15);

    // Reset during beat 2 of a 4-beat write to words 4..7.
    @(posedge aclk); #1;
    bus.awvalid = 1'b1; bus.awaddr = 32'h10; bus.awlen = 8'd3; bus.awid = 4'd7;
    @(negedge aclk);
    check("mid_awready", 32'(bus.awready), 1);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d = $urandom;
      bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = 4'hF; bus.wlast = 1'b0;
      @(posedge aclk);
      model[4 + i] = d;
      #1;
    end
    bus.wdata = $urandom;
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("mid_wready", 32'(bus.wready), 0);   check("mid_bvalid", 32'(bus.bvalid), 0);
    check("mid_rvalid", 32'(bus.rvalid), 0);   check("mid_awready0", 32'(bus.awready), 0);
    check("mid_arready", 32'(bus.arready), 0);
    bus.wvalid = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    axi_write(32'h30, 8'd0, 4'd8);
    axi_read(32'h10, 8'd3, 4'd9);

    // Wrap from the top word, with high address bits set.
    axi_write(32'h1000_003C, 8'd1, 4'd9);
    axi_read(32'h3C, 8'd1, 4'd10);

    // Over-long bursts are clamped to 16 beats.
    axi_write(32'h8, 8'd17, 4'd11);
    axi_read(32'h8, 8'd20, 4'd12);

    // Random mix.
    repeat (14) begin
      if ($urandom_range(0, 1) == 1)
        axi_write($urandom, 8'($urandom_range(0, 7)), 4'($urandom));
      else
        axi_read($urandom, 8'($urandom_range(0, 7)), 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3-style slave responder backed by an on-chip word-addressed SRAM.
- It is the far end of the CPU's AXI master port: it accepts AR/AW/W requests and returns R/B responses.
- Used as the memory model in the SoC-lite bench and as a small on-chip RAM.
- Read and write channels are independent, each with one outstanding transaction.

Parameters:
- ADDR_W, 16, word-address bits; the memory holds 2^ADDR_W 32-bit words and is indexed by addr[ADDR_W+1:2].
- RD_LAT, 1, cycles from the AR handshake to the first rvalid; legal range 1..15.
- MAX_LEN, 15, largest accepted arlen/awlen (beats-1).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- arid/araddr/arlen/arsize/arburst  in  4/32/8/3/2  read address; arlock/arcache/arprot are accepted and ignored
- arvalid  in  1; arready  out  1
- rid  out  4; rdata  out  32; rresp  out  2; rlast  out  1; rvalid  out  1; rready  in  1
- awid/awaddr/awlen/awsize/awburst  in  4/32/8/3/2  write address; awlock/awcache/awprot are accepted and ignored
- awvalid  in  1; awready  out  1
- wid  in  4; wdata  in  32; wstrb  in  4; wlast  in  1; wvalid  in  1; wready  out  1
- bid  out  4; bresp  out  2; bvalid  out  1; bready  in  1

Behaviour:
- Reset: one clock, aclk; reset is asynchronous and active-low on aresetn. While reset is asserted, all of the following are 0: arready, awready, wready, rvalid, bvalid, rlast, rid, bid, rdata, rresp, bresp.
- Reset asserted mid-burst aborts the transaction; both FSMs return to IDLE. The memory array is never reset; its contents are retained.
- rresp and bresp are always 2'b00 (OKAY).
- Burst type is ignored; every burst is treated as INCR by one word per beat. arsize/awsize are ignored (always 4 bytes).
- Addresses wrap modulo 2^ADDR_W words, both for the start address and within a burst.
- Read FSM, R_IDLE:
  - arready=1.
  - On arvalid&arready, latch arid, word address and min(arlen,MAX_LEN), then go to R_WAIT.
- Read FSM, R_WAIT:
  - arready=0; the counter loads RD_LAT-1.
  - When the counter is 0, load rdata from mem[addr] and go to R_DATA. With RD_LAT=1, rvalid is asserted the cycle after the AR handshake.
- Read FSM, R_DATA:
  - rvalid=1, rid is the latched id, rlast=1 when the remaining beat count is 0.
  - rdata, rlast and rid are held stable while rvalid&!rready.
  - On rvalid&rready: if not last, increment the address and reload rdata from mem[next] the same cycle (back-to-back beats, no bubble). If last, go to R_IDLE.
  - arready is first re-asserted the cycle after the last R handshake.
- Write FSM, W_IDLE:
  - awready=1, wready=0.
  - On the AW handshake, latch awid, address and length, then go to W_DATA.
  - W data presented before AW is not accepted; it waits.
- Write FSM, W_DATA:
  - wready=1.
  - Each wvalid&wready writes the bytes of mem[addr] selected by wstrb[i] (byte i = wdata[8i+7:8i]), then increments the address.
  - The beat count comes from awlen. On the beat the count marks last, go to W_RESP; wlast is not used for sequencing.
- Write FSM, W_RESP:
  - bvalid=1, bid is the latched id; held until bready.
  - On the handshake go to W_IDLE; awready is re-asserted the next cycle.
- Read/write collision:
  - The memory write commits at the clock edge of the W handshake.
  - An rdata load in that same cycle from the same word returns the old data; loads in later cycles return the new data.
  - No ordering is enforced between the channels.

Optional Feature:
- AXI_SLV_RAND_DELAY_EN defined:
  - A 16-bit LFSR (seed 16'hACE1, reset by aresetn) gates arready, awready and wready, and delays rvalid and bvalid assertion, each with about 25% stall probability per cycle.
  - Once rvalid or bvalid is asserted it is never dropped before its handshake.
- Undefined: behaviour exactly as specified above, with zero extra stalls.

Decomposition:
- Package axi_slv_pkg holds:
  - read and write FSM state encodings;
  - RESP_OKAY = 2'b00;
  - ID_W = 4, DATA_W = 32, STRB_W = 4;
  - the LFSR seed.
- One sub-module, axi_slv_mem: a 2^ADDR_W x 32 array with a byte-strobed write port and a read port. It is instantiated once; the two FSMs live in axi_sram_slave.

Test Plan:
- Single read: preload mem[4]=32'h1234_5678, RD_LAT=1; AR araddr=32'h10, arlen=0, arid=3 -> rvalid the cycle after AR, rdata=32'h1234_5678, rid=3, rlast=1, rresp=0.
- Write with strobe: AW awaddr=32'h20, awlen=0, awid=5; W wdata=32'hAABB_CCDD, wstrb=4'b0101 over old data 32'h1111_1111 -> bvalid with bid=5, bresp=0; subsequent read of 32'h20 returns 32'h11BB_11DD.
- 4-beat read burst with rready toggling 1,0,1,1,0,1 from word 0 holding 0,1,2,3 -> data 0..3 in order, rlast only on beat 3, outputs stable during stalls.
- Simultaneous traffic: read burst of word 8 while writing 32'hDEAD_BEEF to word 8, with the W handshake in the same cycle as the rdata load -> read returns old data; a re-read returns 32'hDEAD_BEEF.
- Reset mid-burst: deassert aresetn during beat 2 of a 4-beat write -> all valids drop immediately, beats 0-1 remain in memory, next AW is accepted normally after reset.
- Address wrap: ADDR_W=4, 2-beat write starting at word 15 -> beats land in words 15 and 0.
